// File: rtl/jala_core_sequencer.sv
// -----------------------------------------------------------------------------
// jala_core_sequencer
//   Multi-cycle control FSM for the Jala core. Fetches one instruction word
//   over a req/ack port, holds it for the combinational decoder, then steps
//   through DECODE, EXECUTE and WRITEBACK. In WRITEBACK it gates the register
//   file write with the decoder's write enable, advances the PC and counts the
//   retired instruction. A fetch that is never acknowledged ends in a sticky
//   TRAP state that only reset leaves.
//
// Ports
//   clk          in   1   core clock, all state changes on the rising edge
//   reset        in   1   synchronous active-high reset
//   halt         in   1   stop request, honoured in IDLE and WRITEBACK only
//   imem_req     out  1   fetch request, high only in FETCH
//   imem_addr    out  32  fetch address (always the current pc)
//   imem_ack     in   1   imem_rdata is valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   inst         out  32  latched instruction for the decoder
//   dec_write_en in   1   decoder write enable for the current inst
//   rf_write     out  1   register-file write strobe
//   pc           out  32  program counter
//   instret      out  32  retired-instruction count
//   trap         out  1   sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module jala_core_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        dec_write_en,
  output logic        rf_write,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        trap
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit so a
  // timeout of 1 still elaborates.
  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!halt) state_next = S_FETCH;
      // Ack is checked first so an ack on the timeout edge still wins.
      S_FETCH:     if (imem_ack)             state_next = S_DECODE;
                   else if (cnt == CNT_LAST) state_next = S_TRAP;
      S_DECODE:    state_next = S_EXECUTE;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = halt ? S_IDLE : S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      inst    <= NOP;
      instret <= 32'd0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            inst <= imem_rdata;
            cnt  <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITEBACK: begin
          pc      <= pc + 32'd4;
          instret <= instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Acks outside FETCH never reach inst because the latch is gated by state.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign rf_write  = (state == S_WRITEBACK) && dec_write_en;
  assign trap      = (state == S_TRAP);

endmodule

// File: tb/tb_jala_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jala_core_sequencer
//   Scoreboarded bench for jala_core_sequencer. Each acknowledged fetch pushes
//   the expected retirement (instruction, pc after retire, instret, write
//   strobe) to a queue; each retirement seen on instret pops and compares it.
//   A second instance with RESET_PC = 32'hFFFF_FFFC shares the stimulus and
//   is used for the pc wrap case.
// -----------------------------------------------------------------------------
module tb_jala_core_sequencer;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LUI_X1   = 32'h0000_10B7;
  localparam logic [31:0] ADDI_X1  = 32'h0010_8093;
  localparam logic [31:0] ADD_X3   = 32'h0020_81B3;
  localparam logic [31:0] ORI_X1   = 32'h0FF0_E093;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_write_en;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic        rf_write;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        trap;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] inst2;
  logic        rf_write2;
  logic [31:0] pc2;
  logic [31:0] instret2;
  logic        trap2;

  jala_core_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .dec_write_en(dec_write_en),
    .rf_write(rf_write), .pc(pc), .instret(instret), .trap(trap)
  );

  jala_core_sequencer #(.RESET_PC(WRAP_PC), .TIMEOUT_CYCLES(16)) dut_wrap (
    .clk(clk), .reset(reset), .halt(halt),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst2), .dec_write_en(dec_write_en),
    .rf_write(rf_write2), .pc(pc2), .instret(instret2), .trap(trap2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        wr;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_instret = 32'd0;
  logic [31:0] last_instret = 32'd0;
  logic        saw_wr = 1'b0;
  logic        saw_wr2 = 1'b0;

  // Advances one clock from a negedge to the next negedge, feeding the
  // scoreboard on accepted fetches and checking it on each retirement.
  task automatic cycle();
    rec_t r;
    logic rst_at_edge;
    #1;
    if (!reset && imem_req && imem_ack) begin
      exp_pc      = exp_pc + 32'd4;
      exp_instret = exp_instret + 32'd1;
      r.inst = imem_rdata; r.pc = exp_pc; r.instret = exp_instret; r.wr = dec_write_en;
      sb.push_back(r);
    end
    if (rf_write === 1'b1)  saw_wr  = 1'b1;
    if (rf_write2 === 1'b1) saw_wr2 = 1'b1;
    rst_at_edge = reset;
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      sb.delete();
      exp_pc = 32'd0; exp_instret = 32'd0; last_instret = 32'd0;
      saw_wr = 1'b0; saw_wr2 = 1'b0;
    end else if (instret !== last_instret) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_retire: instret=%0d with no pending fetch", instret);
      end else begin
        r = sb.pop_front();
        if (instret !== r.instret) begin
          errors++; $display("FAIL sb_instret: got %0d expected %0d", instret, r.instret);
        end
        checks++;
        if (pc !== r.pc) begin
          errors++; $display("FAIL sb_pc: got %h expected %h", pc, r.pc);
        end
        checks++;
        if (inst !== r.inst) begin
          errors++; $display("FAIL sb_inst: got %h expected %h", inst, r.inst);
        end
        checks++;
        if (saw_wr !== r.wr) begin
          errors++; $display("FAIL sb_rf_write: got %b expected %b", saw_wr, r.wr);
        end
      end
      saw_wr       = 1'b0;
      last_instret = instret;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    halt = 1'b1; imem_ack = 1'b0; dec_write_en = 1'b1;
    do_reset();
    #1;
    checks++; if (pc !== 32'd0)       begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    checks++; if (inst !== NOP)       begin errors++; $display("FAIL reset_inst: got %h expected %h", inst, NOP); end
    checks++; if (instret !== 32'd0)  begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if (trap !== 1'b0)      begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
    checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (rf_write !== 1'b0)  begin errors++; $display("FAIL reset_rf_write: got %b expected 0", rf_write); end
    checks++; if (pc2 !== WRAP_PC)    begin errors++; $display("FAIL reset_pc_wrap_inst: got %h expected %h", pc2, WRAP_PC); end
    cycle();
    checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL idle_halt_req: got %b expected 0", imem_req); end
  endtask

  // Ack in the first FETCH cycle: FETCH, DECODE, EXECUTE, WRITEBACK.
  task automatic test_single_fetch();
    halt = 1'b0; dec_write_en = 1'b1;
    cycle();                                 // IDLE -> FETCH
    imem_ack = 1'b1; imem_rdata = LUI_X1; #1;
    checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL c1_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL c1_addr: got %h expected 0", imem_addr); end
    checks++; if (rf_write !== 1'b0)   begin errors++; $display("FAIL c1_rf_write: got %b expected 0", rf_write); end
    cycle();                                 // -> DECODE
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (inst !== LUI_X1)     begin errors++; $display("FAIL c2_inst: got %h expected %h", inst, LUI_X1); end
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL c2_req: got %b expected 0", imem_req); end
    checks++; if (rf_write !== 1'b0)   begin errors++; $display("FAIL c2_rf_write: got %b expected 0", rf_write); end
    cycle();                                 // -> EXECUTE
    checks++; if (rf_write !== 1'b0)   begin errors++; $display("FAIL c3_rf_write: got %b expected 0", rf_write); end
    halt = 1'b1;
    cycle();                                 // -> WRITEBACK
    #1;
    checks++; if (rf_write !== 1'b1)   begin errors++; $display("FAIL c4_rf_write: got %b expected 1", rf_write); end
    checks++; if (pc !== 32'd0)        begin errors++; $display("FAIL c4_pc: got %h expected 0", pc); end
    cycle();                                 // retire -> IDLE
    checks++; if (rf_write !== 1'b0)   begin errors++; $display("FAIL c5_rf_write: got %b expected 0", rf_write); end
    checks++; if (pc !== 32'd4)        begin errors++; $display("FAIL c5_pc: got %h expected 4", pc); end
  endtask

  // Ack withheld for three FETCH cycles; halt held high is ignored meanwhile.
  task automatic test_delayed_ack();
    halt = 1'b0; dec_write_en = 1'b1;
    cycle();                                 // IDLE -> FETCH
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b0; imem_rdata = 32'hBAD0_0000 + i; #1;
      checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL wait%0d_req: got %b expected 1", i, imem_req); end
      checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL wait%0d_addr: got %h expected 4", i, imem_addr); end
      checks++; if (inst !== LUI_X1)     begin errors++; $display("FAIL wait%0d_inst: got %h expected %h", i, inst, LUI_X1); end
      cycle();
    end
    imem_ack = 1'b1; imem_rdata = ADDI_X1; #1;
    checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL ack4_req: got %b expected 1", imem_req); end
    cycle();                                 // -> DECODE (cycle 5)
    imem_ack = 1'b0;
    checks++; if (inst !== ADDI_X1)    begin errors++; $display("FAIL c5_inst: got %h expected %h", inst, ADDI_X1); end
    cycle();                                 // -> EXECUTE (cycle 6)
    checks++; if (rf_write !== 1'b0)   begin errors++; $display("FAIL c6_rf_write: got %b expected 0", rf_write); end
    cycle();                                 // -> WRITEBACK (cycle 7)
    checks++; if (rf_write !== 1'b1)   begin errors++; $display("FAIL c7_rf_write: got %b expected 1", rf_write); end
    cycle();                                 // retire -> IDLE
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL post7_req: got %b expected 0", imem_req); end
  endtask

  // Halt raised in EXECUTE; spurious ack in DECODE must not touch inst.
  task automatic test_halt_in_execute();
    halt = 1'b0; dec_write_en = 1'b1;
    cycle();                                 // IDLE -> FETCH
    imem_ack = 1'b1; imem_rdata = ADD_X3;
    cycle();                                 // -> DECODE
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    cycle();                                 // -> EXECUTE
    imem_ack = 1'b0;
    checks++; if (inst !== ADD_X3)     begin errors++; $display("FAIL spurious_ack_inst: got %h expected %h", inst, ADD_X3); end
    halt = 1'b1;
    cycle();                                 // -> WRITEBACK
    cycle();                                 // retire -> IDLE
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halted%0d_req: got %b expected 0", i, imem_req); end
      cycle();
    end
    halt = 1'b0;
    cycle();                                 // IDLE -> FETCH
    checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL resume_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'd12) begin errors++; $display("FAIL resume_addr: got %h expected c", imem_addr); end
    imem_ack = 1'b1; imem_rdata = NOP; dec_write_en = 1'b0;
    cycle();
    imem_ack = 1'b0;
    cycle();
    halt = 1'b1;
    cycle();                                 // WRITEBACK with write_en low
    checks++; if (rf_write !== 1'b0)    begin errors++; $display("FAIL no_we_rf_write: got %b expected 0", rf_write); end
    cycle();
  endtask

  // No ack ever: exactly 16 FETCH cycles, then sticky TRAP until reset.
  task automatic test_timeout();
    int n;
    halt = 1'b0; imem_ack = 1'b0; dec_write_en = 1'b1;
    cycle();                                 // IDLE -> FETCH
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    checks++; if (n !== 16)           begin errors++; $display("FAIL timeout_fetch_cycles: got %0d expected 16", n); end
    checks++; if (trap !== 1'b1)      begin errors++; $display("FAIL timeout_trap: got %b expected 1", trap); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = i[0]; halt = i[1];
      #1;
      checks++; if (trap !== 1'b1 || imem_req !== 1'b0 || rf_write !== 1'b0)
        begin errors++; $display("FAIL trap_hold%0d: got trap=%b req=%b wr=%b expected 1,0,0", i, trap, imem_req, rf_write); end
      checks++; if (pc !== 32'd16)    begin errors++; $display("FAIL trap_pc%0d: got %h expected 10", i, pc); end
      cycle();
    end
    imem_ack = 1'b0; halt = 1'b1;
    do_reset();
    checks++; if (trap !== 1'b0)      begin errors++; $display("FAIL trap_reset_trap: got %b expected 0", trap); end
    checks++; if (pc !== 32'd0)       begin errors++; $display("FAIL trap_reset_pc: got %h expected 0", pc); end
  endtask

  // Ack on the 16th FETCH cycle coincides with timeout: ack wins.
  task automatic test_ack_at_timeout();
    halt = 1'b0; imem_ack = 1'b0; dec_write_en = 1'b1;
    cycle();                                 // IDLE -> FETCH
    for (int i = 0; i < 15; i++) cycle();
    imem_ack = 1'b1; imem_rdata = ORI_X1; #1;
    checks++; if (imem_req !== 1'b1)  begin errors++; $display("FAIL edge_req: got %b expected 1", imem_req); end
    cycle();
    imem_ack = 1'b0;
    checks++; if (trap !== 1'b0)      begin errors++; $display("FAIL edge_trap: got %b expected 0", trap); end
    checks++; if (inst !== ORI_X1)    begin errors++; $display("FAIL edge_inst: got %h expected %h", inst, ORI_X1); end
    halt = 1'b1;
    cycle();
    cycle();
    cycle();                                 // retire -> IDLE
  endtask

  // PC wraps on the RESET_PC = FFFF_FFFC instance; write_en low never writes.
  task automatic test_wrap();
    halt = 1'b1; imem_ack = 1'b0;
    do_reset();
    dec_write_en = 1'b0; halt = 1'b0;
    cycle();
    checks++; if (imem_addr2 !== WRAP_PC) begin errors++; $display("FAIL wrap_addr: got %h expected %h", imem_addr2, WRAP_PC); end
    imem_ack = 1'b1; imem_rdata = LUI_X1;
    cycle();
    imem_ack = 1'b0; halt = 1'b1;
    cycle();
    cycle();                                 // WRITEBACK
    cycle();                                 // retire
    checks++; if (pc2 !== 32'd0)      begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc2); end
    checks++; if (instret2 !== 32'd1) begin errors++; $display("FAIL wrap_instret: got %0d expected 1", instret2); end
    checks++; if (saw_wr2 !== 1'b0)   begin errors++; $display("FAIL wrap_rf_write: got %b expected 0", saw_wr2); end
  endtask

  // Reset mid-FETCH and in WRITEBACK returns to IDLE with nothing retired.
  task automatic test_reset_midflight();
    halt = 1'b0; dec_write_en = 1'b1; imem_ack = 1'b0;
    cycle();                                 // IDLE -> FETCH
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; halt = 1'b1;
    checks++; if (imem_req !== 1'b0 || pc !== 32'd0 || instret !== 32'd0 || inst !== NOP)
      begin errors++; $display("FAIL rst_fetch: got req=%b pc=%h instret=%0d inst=%h expected 0,0,0,%h", imem_req, pc, instret, inst, NOP); end
    halt = 1'b0;
    cycle();                                 // IDLE -> FETCH
    imem_ack = 1'b1; imem_rdata = ADDI_X1;
    cycle();
    imem_ack = 1'b0;
    cycle();
    cycle();                                 // WRITEBACK
    checks++; if (rf_write !== 1'b1)  begin errors++; $display("FAIL rst_wb_pre_rf_write: got %b expected 1", rf_write); end
    reset = 1'b1;
    cycle();
    reset = 1'b0; halt = 1'b1; #1;
    checks++; if (rf_write !== 1'b0 || instret !== 32'd0 || pc !== 32'd0 || inst !== NOP || imem_req !== 1'b0)
      begin errors++; $display("FAIL rst_wb: got wr=%b instret=%0d pc=%h inst=%h req=%b expected 0,0,0,%h,0", rf_write, instret, pc, inst, imem_req, NOP); end
    cycle();
    checks++; if (instret !== 32'd0)  begin errors++; $display("FAIL rst_wb_instret: got %0d expected 0", instret); end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; dec_write_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_delayed_ack();
    test_halt_in_execute();
    test_timeout();
    test_ack_at_timeout();
    test_wrap();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
